// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, load/store port and shared SRAM port of the memory arbiter.
// The slave modport is the arbiter; the master modport is the surrounding pipeline plus SRAM.
interface mem_port_arbiter_if;
  // fetch port
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        if_err;

  // load/store port
  logic        d_req;
  logic [7:0]  d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        d_err;

  // shared SRAM port
  logic [7:0]  mem_w_en;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_w_en, mem_address, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_w_en, mem_address, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbitration of the fetch and load/store ports onto the single
// SRAM port. One transaction is IDLE/RESP (grant) -> ACCESS (SRAM driven) -> RESP (response).
module mem_port_arbiter #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  // highest address from which a full doubleword stays inside the SRAM
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 32'd8);

  localparam logic ID_IF = 1'b0;
  localparam logic ID_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Data fault: unsupported mask, mask not naturally aligned, or doubleword past the end.
  function automatic logic data_fault(input logic [7:0] we, input logic [63:0] addr);
    logic bad_s;
    case (we)
      8'h00:   bad_s = 1'b0;
      8'h01:   bad_s = 1'b0;
      8'h03:   bad_s = (addr[0] != 1'b0);
      8'h0F:   bad_s = (addr[1:0] != 2'b00);
      8'hFF:   bad_s = (addr[2:0] != 3'b000);
      default: bad_s = 1'b1;
    endcase
    return bad_s || (addr > LAST_ADDR);
  endfunction

  // Fetch fault: instruction address not word aligned or doubleword past the end.
  function automatic logic fetch_fault(input logic [63:0] addr);
    return (addr[1:0] != 2'b00) || (addr > LAST_ADDR);
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        last_r;
  logic        id_r;
  logic [63:0] addr_r;
  logic [7:0]  mask_r;
  logic [63:0] wdata_r;
  logic        fault_r;

  logic        if_rvalid_r;
  logic        if_err_r;
  logic [63:0] if_rdata_r;
  logic        d_rvalid_r;
  logic        d_err_r;
  logic [63:0] d_rdata_r;

  logic        d_win_s;
  logic        if_win_s;
  logic        d_gnt_s;
  logic        if_gnt_s;
  logic        d_fault_s;
  logic        if_fault_s;
  logic [7:0]  mem_w_en_s;

  // Pick a winner: a lone requester wins, a tie goes to the port that did not win last time.
  always_comb begin
    d_win_s  = 1'b0;
    if_win_s = 1'b0;
    if (bus.d_req && (!bus.if_req || (last_r == ID_IF))) begin
      d_win_s = 1'b1;
    end else if (bus.if_req) begin
      if_win_s = 1'b1;
    end else begin
      d_win_s  = 1'b0;
      if_win_s = 1'b0;
    end
  end

  // Classify both pending requests so the fault flag can be latched with the grant.
  always_comb begin
    d_fault_s  = data_fault(bus.d_we, bus.d_addr);
    if_fault_s = fetch_fault(bus.if_addr);
  end

  // Next-state and grant decode; grants only when no SRAM access is in progress.
  always_comb begin
    state_nxt_s = state_r;
    d_gnt_s     = 1'b0;
    if_gnt_s    = 1'b0;
    case (state_r)
      IDLE, RESP: begin
        if (rst_n && (d_win_s || if_win_s)) begin
          d_gnt_s     = d_win_s;
          if_gnt_s    = if_win_s;
          state_nxt_s = ACCESS;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        state_nxt_s = RESP;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch the winning request and move the round-robin pointer to the winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r  <= ID_IF;
      id_r    <= ID_IF;
      addr_r  <= 64'd0;
      mask_r  <= 8'd0;
      wdata_r <= 64'd0;
      fault_r <= 1'b0;
    end else if (d_gnt_s) begin
      last_r  <= ID_D;
      id_r    <= ID_D;
      addr_r  <= bus.d_addr;
      mask_r  <= bus.d_we;
      wdata_r <= bus.d_wdata;
      fault_r <= d_fault_s;
    end else if (if_gnt_s) begin
      last_r  <= ID_IF;
      id_r    <= ID_IF;
      addr_r  <= bus.if_addr;
      mask_r  <= 8'd0;
      wdata_r <= wdata_r;
      fault_r <= if_fault_s;
    end else begin
      last_r  <= last_r;
      id_r    <= id_r;
      addr_r  <= addr_r;
      mask_r  <= mask_r;
      wdata_r <= wdata_r;
      fault_r <= fault_r;
    end
  end

  // SRAM write enable: only a non-faulting store during ACCESS, suppressed while reset is low.
  always_comb begin
    mem_w_en_s = 8'd0;
    if ((state_r == ACCESS) && rst_n && (id_r == ID_D) && !fault_r) begin
      mem_w_en_s = mask_r;
    end else begin
      mem_w_en_s = 8'd0;
    end
  end

  // Response registers: load the winner's response at the end of ACCESS, pulse rvalid one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rvalid_r <= 1'b0;
      if_err_r    <= 1'b0;
      if_rdata_r  <= 64'd0;
      d_rvalid_r  <= 1'b0;
      d_err_r     <= 1'b0;
      d_rdata_r   <= 64'd0;
    end else if (state_r == ACCESS) begin
      if (id_r == ID_D) begin
        d_rvalid_r  <= 1'b1;
        d_err_r     <= fault_r;
        d_rdata_r   <= (!fault_r && (mask_r == 8'd0)) ? bus.mem_read_data : 64'd0;
        if_rvalid_r <= 1'b0;
      end else begin
        if_rvalid_r <= 1'b1;
        if_err_r    <= fault_r;
        if_rdata_r  <= fault_r ? 64'd0 : bus.mem_read_data;
        d_rvalid_r  <= 1'b0;
      end
    end else begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
    end
  end

  assign bus.if_gnt         = if_gnt_s;
  assign bus.if_rvalid      = if_rvalid_r;
  assign bus.if_rdata       = if_rdata_r;
  assign bus.if_err         = if_err_r;
  assign bus.d_gnt          = d_gnt_s;
  assign bus.d_rvalid       = d_rvalid_r;
  assign bus.d_rdata        = d_rdata_r;
  assign bus.d_err          = d_err_r;
  assign bus.mem_w_en       = mem_w_en_s;
  assign bus.mem_address    = addr_r;
  assign bus.mem_write_data = wdata_r;

endmodule
